// File: rtl/ovl_collect_pkg.sv
// Shared types and helpers for the assertion-fire collector: FSM state,
// saturating add and population count.
package ovl_collect_pkg;

  typedef enum logic {
    COLL_IDLE   = 1'b0,
    COLL_REPORT = 1'b1
  } coll_state_e;

  localparam int unsigned POP_BITS = 64;
  localparam int unsigned POP_W    = 7;

  // Unsigned add clamped to the all-ones value of a width-bit result (width <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    lim = (33'd1 << width) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  // Number of set bits in a vector of up to POP_BITS bits.
  function automatic logic [POP_W-1:0] popcount(input logic [POP_BITS-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(POP_BITS); i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ovl_rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping at N-1 back to 0.
module ovl_rr_arbiter #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id
);

  int unsigned     idx;
  logic [IW-1:0]   idx_w;

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx   = (32'(ptr) + (N - 1 - k)) % N;
      idx_w = IW'(idx);
      if (req[idx_w]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx_w;
      end
    end
  end

endmodule

// File: rtl/ovl_fire_collector.sv
// Collects checker fire pulses into per-checker saturating counts and
// serialises one report per firing checker over a valid/ready stream.
module ovl_fire_collector
  import ovl_collect_pkg::*;
#(
  parameter int unsigned NUM_CHECKERS = 8,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned ID_WIDTH     = $clog2(NUM_CHECKERS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [NUM_CHECKERS-1:0] fire,
  output logic                    rpt_valid,
  input  logic                    rpt_ready,
  output logic [ID_WIDTH-1:0]     rpt_id,
  output logic [CNT_WIDTH-1:0]    rpt_count,
  output logic                    rpt_sat,
  output logic                    any_fire,
  output logic [CNT_WIDTH-1:0]    total_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ID_WIDTH-1:0]  LAST_ID = ID_WIDTH'(NUM_CHECKERS - 1);

  coll_state_e               state;
  logic [NUM_CHECKERS-1:0]   pending;
  logic [NUM_CHECKERS-1:0]   fire_acc;
  logic [CNT_WIDTH-1:0]      count [NUM_CHECKERS];
  logic [ID_WIDTH-1:0]       ptr;
  logic [ID_WIDTH-1:0]       gnt_id;
  logic                      gnt_valid;
  logic                      grant;
  logic [CNT_WIDTH-1:0]      gnt_count;
  logic [CNT_WIDTH-1:0]      total_next;

  ovl_rr_arbiter #(
    .N  (NUM_CHECKERS),
    .IW (ID_WIDTH)
  ) u_arb (
    .req       (pending),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Qualified fires and grant decision; a clear cycle never grants.
  always_comb begin
    fire_acc   = (enable && !clear) ? fire : '0;
    grant      = (state == COLL_IDLE) && gnt_valid && !clear;
    gnt_count  = count[gnt_id];
    total_next = CNT_WIDTH'(sat_add(32'(total_count),
                                    32'(popcount(POP_BITS'(fire_acc))),
                                    CNT_WIDTH));
  end

  // Pending flags and counters; the granted slot restarts from this cycle's fire.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pending     <= '0;
      total_count <= '0;
      any_fire    <= 1'b0;
      for (int i = 0; i < int'(NUM_CHECKERS); i++) begin
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CHECKERS); i++) begin
        if (grant && (gnt_id == ID_WIDTH'(i))) begin
          pending[i] <= fire_acc[i];
          count[i]   <= CNT_WIDTH'(fire_acc[i]);
        end else if (fire_acc[i]) begin
          pending[i] <= 1'b1;
          count[i]   <= (count[i] == CNT_MAX) ? CNT_MAX : count[i] + CNT_WIDTH'(1);
        end
      end
      total_count <= total_next;
      any_fire    <= any_fire | (|fire_acc);
    end
  end

  // Report FSM: load the granted entry, hold it until the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLL_IDLE;
      ptr       <= '0;
      rpt_valid <= 1'b0;
      rpt_id    <= '0;
      rpt_count <= '0;
      rpt_sat   <= 1'b0;
    end else begin
      case (state)
        COLL_IDLE: begin
          if (grant) begin
            rpt_valid <= 1'b1;
            rpt_id    <= gnt_id;
            rpt_count <= gnt_count;
            rpt_sat   <= (gnt_count == CNT_MAX);
            ptr       <= (gnt_id == LAST_ID) ? '0 : gnt_id + ID_WIDTH'(1);
            state     <= COLL_REPORT;
          end
        end
        COLL_REPORT: begin
          if (rpt_ready) begin
            rpt_valid <= 1'b0;
            state     <= COLL_IDLE;
          end
        end
        default: state <= COLL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Bench for ovl_fire_collector: directed table, corner sequences and random
// stimulus compared against a transaction-level reference model.
module tb_ovl_fire_collector;

  localparam int N    = 8;
  localparam int CW   = 4;
  localparam int IW   = 3;
  localparam int MAXV = 15;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk;
  logic          reset, enable, clear, rpt_ready;
  logic [N-1:0]  fire;
  logic          rpt_valid, rpt_sat, any_fire;
  logic [IW-1:0] rpt_id;
  logic [CW-1:0] rpt_count, total_count;

  int checks;
  int errors;

  ovl_fire_collector #(
    .NUM_CHECKERS (N),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .fire        (fire),
    .rpt_valid   (rpt_valid),
    .rpt_ready   (rpt_ready),
    .rpt_id      (rpt_id),
    .rpt_count   (rpt_count),
    .rpt_sat     (rpt_sat),
    .any_fire    (any_fire),
    .total_count (total_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what has been seen, what is owed, what is on the port.
  bit m_pend [N];
  int m_cnt  [N];
  int m_total;
  bit m_any;
  int m_ptr;
  bit m_valid;
  int m_id;
  int m_rcnt;
  bit m_sat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic en, input logic clr,
                            input logic [N-1:0] f, input logic rdy);
    logic [N-1:0] acc;
    bit found;
    int g;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_cnt[i]  = 0;
      end
      m_total = 0; m_any = 0; m_ptr = 0;
      m_valid = 0; m_id = 0; m_rcnt = 0; m_sat = 0;
      return;
    end
    acc = (en && !clr) ? f : '0;
    found = 0;
    g = 0;
    if (m_valid) begin
      if (rdy) m_valid = 0;
    end else if (!clr) begin
      for (int k = 0; k < N; k++) begin
        if (!found && m_pend[(m_ptr + k) % N]) begin
          found = 1;
          g = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_valid = 1;
        m_id    = g;
        m_rcnt  = m_cnt[g];
        m_sat   = (m_cnt[g] == MAXV);
        m_ptr   = (g + 1) % N;
        m_pend[g] = 0;
        m_cnt[g]  = 0;
      end
    end
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_cnt[i]  = 0;
      end
      m_total = 0;
      m_any   = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          m_pend[i] = 1;
          m_cnt[i]  = (m_cnt[i] >= MAXV) ? MAXV : m_cnt[i] + 1;
        end
      end
      m_total = m_total + $countones(acc);
      if (m_total > MAXV) m_total = MAXV;
      if (acc != '0) m_any = 1;
    end
  endtask

  // One clock: drive, advance model across the edge, compare just after it.
  task automatic step(input logic r, input logic en, input logic clr,
                      input logic [N-1:0] f, input logic rdy);
    reset = r; enable = en; clear = clr; fire = f; rpt_ready = rdy;
    @(posedge clk);
    model_step(r, en, clr, f, rdy);
    #1;
    check("mdl_valid", 32'(rpt_valid), 32'(m_valid));
    if (m_valid) begin
      check("mdl_id", 32'(rpt_id), m_id);
      check("mdl_count", 32'(rpt_count), m_rcnt);
      check("mdl_sat", 32'(rpt_sat), 32'(m_sat));
    end
    check("mdl_total", 32'(total_count), m_total);
    check("mdl_any", 32'(any_fire), 32'(m_any));
  endtask

  typedef struct {
    int rst; int en; int clr; logic [N-1:0] f; int rdy;
    int ev; int eid; int ecnt; int esat; int etot; int eany;
  } vec_t;

  vec_t vt [18];

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; enable = 1'b0; clear = 1'b0; fire = '0; rpt_ready = 1'b0;

    //         rst en clr fire   rdy  ev id cnt sat tot any
    vt[0]  = '{1, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 1, 0, 8'h04, 1,   0, 0, 0, 0, 1, 1};
    vt[2]  = '{0, 1, 0, 8'h00, 1,   1, 2, 1, 0, 1, 1};
    vt[3]  = '{0, 1, 0, 8'h00, 1,   0, 0, 0, 0, 1, 1};
    vt[4]  = '{0, 1, 0, 8'h00, 1,   0, 0, 0, 0, 1, 1};
    vt[5]  = '{1, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 0};
    vt[6]  = '{0, 1, 0, 8'h09, 1,   0, 0, 0, 0, 2, 1};
    vt[7]  = '{0, 1, 0, 8'h09, 1,   1, 0, 1, 0, 4, 1};
    vt[8]  = '{0, 1, 0, 8'h09, 1,   0, 0, 0, 0, 6, 1};
    vt[9]  = '{0, 1, 0, 8'h00, 1,   1, 3, 3, 0, 6, 1};
    vt[10] = '{0, 1, 0, 8'h00, 1,   0, 0, 0, 0, 6, 1};
    vt[11] = '{0, 1, 0, 8'h00, 1,   1, 0, 2, 0, 6, 1};
    vt[12] = '{0, 1, 0, 8'h00, 1,   0, 0, 0, 0, 6, 1};
    vt[13] = '{0, 1, 0, 8'h00, 1,   0, 0, 0, 0, 6, 1};
    vt[14] = '{0, 0, 0, 8'hFF, 1,   0, 0, 0, 0, 6, 1};
    vt[15] = '{0, 0, 0, 8'h00, 1,   0, 0, 0, 0, 6, 1};
    vt[16] = '{0, 1, 1, 8'hFF, 1,   0, 0, 0, 0, 0, 0};
    vt[17] = '{0, 1, 0, 8'h00, 1,   0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 18; i++) begin
      step(1'(vt[i].rst), 1'(vt[i].en), 1'(vt[i].clr), vt[i].f, 1'(vt[i].rdy));
      check($sformatf("tbl%0d_valid", i), 32'(rpt_valid), vt[i].ev);
      if (vt[i].ev != 0 || vt[i].rst != 0) begin
        check($sformatf("tbl%0d_id", i), 32'(rpt_id), vt[i].eid);
        check($sformatf("tbl%0d_count", i), 32'(rpt_count), vt[i].ecnt);
        check($sformatf("tbl%0d_sat", i), 32'(rpt_sat), vt[i].esat);
      end
      check($sformatf("tbl%0d_total", i), 32'(total_count), vt[i].etot);
      check($sformatf("tbl%0d_any", i), 32'(any_fire), vt[i].eany);
    end

    // Backpressure: id2 held across a 10-cycle stall while checker 5 fires 4 times.
    step(H, L, L, 8'h00, L);
    step(L, H, L, 8'h04, L);
    step(L, H, L, 8'h00, L);
    for (int c = 0; c < 10; c++) begin
      step(L, H, L, (c % 2 == 0 && c < 8) ? 8'h20 : 8'h00, L);
      check("bp_hold_valid", 32'(rpt_valid), 1);
      check("bp_hold_id", 32'(rpt_id), 2);
      check("bp_hold_count", 32'(rpt_count), 1);
    end
    step(L, H, L, 8'h00, H);
    check("bp_accept_valid", 32'(rpt_valid), 0);
    step(L, H, L, 8'h00, H);
    check("bp_next_id", 32'(rpt_id), 5);
    check("bp_next_count", 32'(rpt_count), 4);
    step(L, H, L, 8'h00, H);

    // Saturation: checker 1 fires 20 cycles while checker 0's report is stalled.
    step(H, L, L, 8'h00, L);
    step(L, H, L, 8'h03, L);
    for (int c = 0; c < 19; c++) step(L, H, L, 8'h02, L);
    check("sat_block_id", 32'(rpt_id), 0);
    check("sat_total", 32'(total_count), 15);
    step(L, H, L, 8'h00, H);
    step(L, H, L, 8'h00, H);
    check("sat_valid", 32'(rpt_valid), 1);
    check("sat_id", 32'(rpt_id), 1);
    check("sat_count", 32'(rpt_count), 15);
    check("sat_flag", 32'(rpt_sat), 1);
    step(L, H, L, 8'h00, H);

    // Fire landing on the grant edge goes into the following report.
    step(H, L, L, 8'h00, L);
    step(L, H, L, 8'h40, H);
    step(L, H, L, 8'h40, H);
    check("gf_first_id", 32'(rpt_id), 6);
    check("gf_first_count", 32'(rpt_count), 1);
    step(L, H, L, 8'h00, H);
    step(L, H, L, 8'h00, H);
    check("gf_second_valid", 32'(rpt_valid), 1);
    check("gf_second_id", 32'(rpt_id), 6);
    check("gf_second_count", 32'(rpt_count), 1);
    step(L, H, L, 8'h00, H);

    // Reset while a report is outstanding.
    step(H, L, L, 8'h00, L);
    step(L, H, L, 8'h01, L);
    step(L, H, L, 8'h00, L);
    check("rr_pre_valid", 32'(rpt_valid), 1);
    step(H, H, L, 8'hFF, H);
    check("rr_valid", 32'(rpt_valid), 0);
    check("rr_total", 32'(total_count), 0);
    check("rr_any", 32'(any_fire), 0);
    check("rr_id", 32'(rpt_id), 0);
    check("rr_count", 32'(rpt_count), 0);
    for (int c = 0; c < 3; c++) step(L, H, L, 8'h00, H);
    check("rr_quiet", 32'(rpt_valid), 0);

    // Clear while a report is outstanding: it completes, nothing follows.
    step(H, L, L, 8'h00, L);
    step(L, H, L, 8'h03, L);
    step(L, H, L, 8'h00, L);
    step(L, H, H, 8'hFF, L);
    check("clr_hold_valid", 32'(rpt_valid), 1);
    check("clr_hold_id", 32'(rpt_id), 0);
    check("clr_total", 32'(total_count), 0);
    check("clr_any", 32'(any_fire), 0);
    step(L, H, L, 8'h00, H);
    for (int c = 0; c < 4; c++) step(L, H, L, 8'h00, H);
    check("clr_quiet", 32'(rpt_valid), 0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] f;
      f = (c % 1000 < 500) ? (8'($urandom) & 8'($urandom) & 8'($urandom)) : 8'($urandom);
      step(($urandom_range(0, 599) == 0) ? H : L,
           ($urandom_range(0, 9) != 0) ? H : L,
           ($urandom_range(0, 149) == 0) ? H : L,
           f,
           ($urandom_range(0, 3) != 0) ? H : L);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ovl_fire_collector.md
Name: ovl_fire_collector

Overview:
- Gathers the 1-bit fire pulses from NUM_CHECKERS assertion/assumption checker instances and accumulates per-checker occurrence counts.
- Serialises one report per firing checker onto a valid/ready stream, consumed by the testbench scoreboard or the debug trace unit.
- Round-robin arbitration ensures a permanently firing checker cannot starve the others.

Parameters:
- NUM_CHECKERS, 8, number of monitored checker fire inputs (>=2).
- CNT_WIDTH, 16, width of each per-checker occurrence counter and of total_count.
- ID_WIDTH, $clog2(NUM_CHECKERS), width of the report id (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when 0, fire inputs are ignored; reporting of already-pending entries continues.
- clear  input  1  synchronous clear of pending flags, counters, any_fire and total_count.
- fire  input  NUM_CHECKERS  bit i = checker i fired this cycle.
- rpt_valid  output  1  report available.
- rpt_ready  input  1  consumer accepts report.
- rpt_id  output  ID_WIDTH  index of the reported checker.
- rpt_count  output  CNT_WIDTH  fires of rpt_id since its previous report.
- rpt_sat  output  1  rpt_count saturated (true count >= 2^CNT_WIDTH-1).
- any_fire  output  1  sticky: some checker has fired since reset/clear.
- total_count  output  CNT_WIDTH  saturating total of fire bits seen (popcount per cycle).

Behaviour:
- Reset (reset=1 at an edge): pending, count[], total_count, any_fire, rpt_valid, rpt_id, rpt_count, rpt_sat all become 0; state IDLE; arbiter pointer 0. Reset overrides clear and all other inputs, including mid-report.
- Accumulation (enable=1, fire[i]=1): pending[i] <= 1; count[i] increments, saturating at all-ones. total_count adds popcount(fire), saturating. any_fire <= 1.
- FSM states:
  - IDLE: if any pending bit is set, grant the first set index searching upward from the pointer, with wrap-around. Load rpt_id = i, rpt_count = count[i] (registered value), rpt_sat = (count[i] == max). Pointer <= i+1 mod NUM_CHECKERS. Go to REPORT.
  - In the grant cycle, pending[i] and count[i] are cleared. If fire[i]&enable is set in that same cycle, pending[i] <= 1 and count[i] <= 1, so the same-cycle fire goes into the next report and is never lost or double-counted.
  - REPORT: rpt_valid = 1. rpt_id, rpt_count and rpt_sat are held stable until rpt_valid&rpt_ready. On the handshake, rpt_valid <= 0 and state goes to IDLE.
- Minimum gap between reports: one IDLE cycle, so throughput is one report per 2 cycles.
- Latency: fire at edge t -> pending visible after t -> grant at edge t+1 -> rpt_valid high after edge t+1, i.e. 2 cycles from fire to rpt_valid.
- clear=1: pending, count[], total_count and any_fire are cleared; fire inputs in the same cycle are ignored. An in-flight report (REPORT state) is not aborted and completes normally. In IDLE, no grant occurs on a clear cycle.
- rpt_ready while rpt_valid=0 has no effect. rpt_valid never drops without a handshake except on reset.
- NUM_CHECKERS not a power of two: pointer wraps at NUM_CHECKERS-1 -> 0; ids >= NUM_CHECKERS are never produced.

Decomposition:
- Shared package ovl_collect_pkg:
  - state enum {COLL_IDLE, COLL_REPORT}
  - saturating-add function sat_add(a, b, width)
  - popcount function
- One sub-module, ovl_rr_arbiter:
  - parameter N
  - inputs req[N], ptr
  - outputs gnt_valid, gnt_id
  - purely combinational round-robin priority search.
- Counters, pending flags and the FSM stay in ovl_fire_collector.

Test Plan:
- Single fire: after reset, fire=8'h04 for 1 cycle, rpt_ready=1 -> rpt_valid rises 2 cycles later with rpt_id=2, rpt_count=1, rpt_sat=0. total_count=1, any_fire=1.
- Round-robin: fire=8'h09 held for 3 cycles, rpt_ready=1 -> reports id0 (count 1), id3 (count 3), id0 (count 2), id3 (count 0 impossible: no third id3 report unless it fired again). Check no lost counts: sum of reported counts = 6.
- Backpressure: report pending, rpt_ready=0 for 10 cycles while fire[5] pulses 4 times -> rpt_id/rpt_count stable across the stall. After acceptance, the next report is id5 with the accumulated count.
- Saturation: CNT_WIDTH=4, fire[1] held 20 cycles with rpt_ready=0 and another report occupying the port -> id1 report shows rpt_count=15, rpt_sat=1. total_count=15.
- Same-cycle fire at grant: fire[6] pulsed on exactly the grant edge of id6 -> current report count excludes it; a second id6 report follows with rpt_count=1.
- Reset/clear/enable:
  - reset asserted in REPORT -> next cycle rpt_valid=0 and all counters 0.
  - clear in REPORT -> report completes, then no further reports.
  - enable=0 with fire=8'hFF -> no reports, total_count=0.
